// File: rtl/obi_mem_pkg.sv
// Shared types and constants for the OBI memory responder and its response queue.
package obi_mem_pkg;

    localparam int          TS_WIDTH  = 8;
    localparam logic [31:0] ERR_RDATA = 32'hBADC0DE0;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef struct packed {
        logic [31:0]         rdata;
        logic                err;
        logic [TS_WIDTH-1:0] ts;
    } resp_entry_t;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/obi_resp_fifo.sv
// In-order response queue of resp_entry_t with a head view and registered occupancy.
module obi_resp_fifo
    import obi_mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        push_i,
    input  resp_entry_t push_data_i,
    input  logic        pop_i,
    output resp_entry_t head_o,
    output logic [3:0]  count_o
);

    localparam int               PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);

    resp_entry_t      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [3:0]       count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + {3'b0, push_i} - {3'b0, pop_i};
        if (push_i) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
        if (pop_i)  rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset; occupancy alone decides validity.
    always_ff @(posedge clk_i) begin
        if (push_i) mem[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/obi_mem_responder.sv
// OBI data-port responder: stalled grants, word memory, in-order responses after RESP_LAT.
// Optional macro OBI_RESP_RANDOM_STALL_EN masks the grant stall with an LFSR.
module obi_mem_responder
    import obi_mem_pkg::*;
#(
    parameter int ADDR_WIDTH      = 10,
    parameter int MAX_OUTSTANDING = 4,
    parameter int RESP_LAT        = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    input  logic [3:0]  gnt_stall_i,
    output logic [3:0]  outstanding_o
);

    localparam logic [3:0]          MAX_CNT = 4'(MAX_OUTSTANDING);
    localparam logic [TS_WIDTH-1:0] LAT_TS  = TS_WIDTH'(RESP_LAT);

    logic [31:0]           mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] idx;
    logic                  addr_err;
    logic                  hs;
    logic [3:0]            stall_q, stall_d, stall_load;
    logic [TS_WIDTH-1:0]   ts_q, ts_d, age;
    logic                  rvalid_q, rvalid_d, err_q, err_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [3:0]            count;
    logic                  pop;
    resp_entry_t           push_entry, head;

    assign idx      = data_addr_i[ADDR_WIDTH+1:2];
    assign addr_err = |data_addr_i[31:ADDR_WIDTH+2];

    // Grant looks only at registered occupancy, so a same-cycle pop never frees a slot.
    assign data_gnt_o = !rst_i && data_req_i && (stall_q == 4'd0) && (count < MAX_CNT);
    assign hs         = data_req_i && data_gnt_o;

`ifdef OBI_RESP_RANDOM_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (hs) lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) lfsr_q <= LFSR_SEED;
        else       lfsr_q <= lfsr_d;
    end

    assign stall_load = lfsr_q[3:0] & gnt_stall_i;
`else
    assign stall_load = gnt_stall_i;
`endif

    always_comb begin
        push_entry.ts    = ts_q;
        push_entry.err   = addr_err;
        push_entry.rdata = addr_err ? ERR_RDATA : (data_we_i ? 32'h0 : mem[idx]);
    end

    always_ff @(posedge clk_i) begin
        if (hs && data_we_i && !addr_err) mem[idx] <= merge_bytes(mem[idx], data_wdata_i, data_be_i);
    end

    obi_resp_fifo #(.DEPTH(MAX_OUTSTANDING)) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (hs),
        .push_data_i(push_entry),
        .pop_i      (pop),
        .head_o     (head),
        .count_o    (count)
    );

    // Modular age keeps working across timestamp wrap.
    assign age = ts_q - head.ts;
    assign pop = (count != 4'd0) && (age >= LAT_TS);

    always_comb begin
        ts_d     = ts_q + 1'b1;
        stall_d  = hs ? stall_load : ((stall_q != 4'd0) ? stall_q - 4'd1 : 4'd0);
        rvalid_d = pop;
        rdata_d  = pop ? head.rdata : rdata_q;
        err_d    = pop ? head.err : 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ts_q     <= '0;
            stall_q  <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            ts_q     <= ts_d;
            stall_q  <= stall_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign data_rvalid_o = rvalid_q;
    assign data_rdata_o  = rdata_q;
    assign data_err_o    = err_q;
    assign outstanding_o = count;

endmodule

// File: tb/tb_obi_mem_responder.sv
// Scoreboard bench for obi_mem_responder: random and directed OBI traffic vs a reference model.
module tb_obi_mem_responder;

    localparam int MAX = 4;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0, we = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0]  be = '0, stall = '0;
    logic        gnt, rvalid, err;
    logic [31:0] rdata;
    logic [3:0]  outst;

    logic        req2 = 1'b0;
    logic        gnt2, rvalid2, err2;
    logic [31:0] rdata2;
    logic [3:0]  outst2;

    int tests = 0, fails = 0, cyc = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    logic [31:0] ref_mem [1024];
    int          next_allowed = 0;

    obi_mem_responder #(.ADDR_WIDTH(10), .MAX_OUTSTANDING(MAX), .RESP_LAT(LAT)) u_dut (
        .clk_i(clk), .rst_i(rst), .data_req_i(req), .data_gnt_o(gnt), .data_addr_i(addr),
        .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata), .data_rvalid_o(rvalid),
        .data_rdata_o(rdata), .data_err_o(err), .gnt_stall_i(stall), .outstanding_o(outst)
    );

    obi_mem_responder #(.ADDR_WIDTH(10), .MAX_OUTSTANDING(2), .RESP_LAT(10)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .data_req_i(req2), .data_gnt_o(gnt2), .data_addr_i(32'h0001_0000),
        .data_we_i(1'b0), .data_be_i(4'hF), .data_wdata_i(32'h0), .data_rvalid_o(rvalid2),
        .data_rdata_o(rdata2), .data_err_o(err2), .gnt_stall_i(4'd0), .outstanding_o(outst2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: reference model of grant, occupancy and in-order responses.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            next_allowed = 0;
            chk("rst_gnt", {31'b0, gnt}, 32'd0);
            chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
            chk("rst_outst", {28'b0, outst}, 32'd0);
        end else begin
            if (rvalid) begin
                if (q.size() == 0) begin
                    chk("unexpected_rvalid", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("rdata", rdata, e.rdata);
                    chk("err", {31'b0, err}, {31'b0, e.err});
                    chk("resp_cycle", 32'(cyc), 32'(e.cyc));
                end
            end else begin
                chk("err_idle", {31'b0, err}, 32'd0);
                if (q.size() != 0 && q[0].cyc <= cyc) begin
                    chk("missing_rvalid", 32'(cyc), 32'(q[0].cyc));
                    void'(q.pop_front());
                end
            end
            chk("gnt", {31'b0, gnt}, {31'b0, (req && cyc >= next_allowed && q.size() < MAX)});
            chk("outstanding", {28'b0, outst}, 32'(q.size()));
            if (req && gnt) begin
                exp_t        e;
                logic [9:0]  ix;
                ix      = addr[11:2];
                e.err   = |addr[31:12];
                e.rdata = e.err ? 32'hBADC0DE0 : (we ? 32'h0 : ref_mem[ix]);
                e.cyc   = cyc + LAT + 1;
                if (we && !e.err) begin
                    for (int b = 0; b < 4; b++)
                        if (be[b]) ref_mem[ix][8*b +: 8] = wdata[8*b +: 8];
                end
                q.push_back(e);
                next_allowed = cyc + 1 + int'(stall);
            end
        end
    end

    task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] d, input logic [3:0] s);
        req = 1'b1; we = w; addr = a; be = b; wdata = d; stall = s;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (gnt) begin
                @(posedge clk); #1;
                return;
            end
        end
        tests++; fails++;
        $display("FAIL grant_timeout at cycle %0d: got no grant expected grant", cyc);
        req = 1'b0;
    endtask

    task automatic idle(input int n);
        req = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Single directed read with explicit latency and data expectations.
    task automatic read_direct(input string nm, input logic [31:0] a,
                               input logic [31:0] exp_d, input logic exp_e);
        int c0;
        bit seen;
        c0 = cyc; seen = 0;
        issue(1'b0, a, 4'hF, 32'h0, 4'd0);
        idle(0);
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (rvalid) begin
                seen = 1;
                chk({nm, "_lat"}, 32'(cyc - c0), 32'(LAT + 1));
                chk({nm, "_rdata"}, rdata, exp_d);
                chk({nm, "_err"}, {31'b0, err}, {31'b0, exp_e});
            end
        end
        if (!seen) chk({nm, "_timeout"}, 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog at cycle %0d: got no finish expected finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int g[$], r[$];
        int maxo;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int w = 0; w < 16; w++)
            issue(1'b1, 32'(w) << 2, 4'hF,
                  (w == 5) ? 32'h12345678 : (w == 8) ? 32'h0 : $urandom, 4'd0);
        idle(4);

        read_direct("single_read", 32'h14, 32'h12345678, 1'b0);
        issue(1'b1, 32'h20, 4'b0010, 32'hAABBCCDD, 4'd0);
        idle(2);
        read_direct("byte_write", 32'h20, 32'h0000CC00, 1'b0);
        read_direct("addr_err", 32'h0001_0000, 32'hBADC0DE0, 1'b1);
        issue(1'b1, 32'h0001_0014, 4'hF, 32'hFFFFFFFF, 4'd0);
        idle(2);
        read_direct("err_no_write", 32'h14, 32'h12345678, 1'b0);

        idle(4);
        c0 = cyc;
        for (int i = 0; i < 10; i++) issue(1'b0, 32'(i) << 2, 4'hF, 32'h0, 4'd0);
        chk("b2b_span", 32'(cyc - c0), 32'd10);
        idle(6);

        c0 = cyc;
        for (int i = 0; i < 4; i++) issue(1'b0, 32'(i) << 2, 4'hF, 32'h0, 4'd3);
        chk("stall3_span", 32'(cyc - c0), 32'd13);
        idle(8);

        for (int n = 0; n < 250; n++) begin
            logic [31:0] a;
            a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = a | (32'h1 << (12 + $urandom_range(0, 19)));
            issue($urandom_range(0, 1) == 1, a, 4'($urandom), $urandom,
                  ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 3)) : 4'd0);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 3));
        end
        idle(8);

        // Reset with transactions still in flight.
        for (int i = 0; i < 3; i++) issue(1'b0, 32'(i) << 2, 4'hF, 32'h0, 4'd0);
        req = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle(10);
        chk("post_rst_outst", {28'b0, outst}, 32'd0);

        // Shallow queue with long latency: third grant waits for the first response.
        maxo = 0;
        req2 = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (gnt2) g.push_back(cyc);
            if (rvalid2) begin
                r.push_back(cyc);
                chk("q2_rdata", rdata2, 32'hBADC0DE0);
                chk("q2_err", {31'b0, err2}, 32'd1);
            end
            if (int'(outst2) > maxo) maxo = int'(outst2);
            @(posedge clk); #1;
            if (g.size() >= 3) req2 = 1'b0;
        end
        req2 = 1'b0;
        chk("q2_grants", 32'(g.size()), 32'd3);
        chk("q2_resps", 32'(r.size()), 32'd3);
        chk("q2_max_outst", 32'(maxo), 32'd2);
        if (g.size() == 3 && r.size() == 3) begin
            chk("q2_g1", 32'(g[1]), 32'(g[0] + 1));
            chk("q2_r0", 32'(r[0]), 32'(g[0] + 11));
            chk("q2_g2", 32'(g[2]), 32'(r[0]));
        end

        idle(4);
        chk("drain", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/obi_mem_responder.md
Name: obi_mem_responder

Overview:
- OBI data-port responder: the target end of the core's data bus, built as an alternative to the plain testbench RAM.
- Accepts requests with programmable grant stalls.
- Services reads and writes to an internal word memory.
- Returns responses strictly in order after a fixed minimum latency, with up to MAX_OUTSTANDING transactions in flight.
- Purpose: stress the core's LSU against back-pressure and pipelined responses.

Parameters:
- ADDR_WIDTH, 10, word-address bits; memory holds 2**ADDR_WIDTH 32-bit words.
- MAX_OUTSTANDING, 4, response-queue depth (legal range 1..8).
- RESP_LAT, 2, minimum cycles from grant to rvalid (legal range 1..15).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- data_req_i  in  1  OBI request.
- data_gnt_o  out  1  OBI grant.
- data_addr_i  in  32  byte address.
- data_we_i  in  1  write enable.
- data_be_i  in  4  byte enables.
- data_wdata_i  in  32  write data.
- data_rvalid_o  out  1  response valid.
- data_rdata_o  out  32  read data.
- data_err_o  out  1  response error.
- gnt_stall_i  in  4  grant-stall cycles inserted after each handshake.
- outstanding_o  out  4  number of accepted transactions not yet responded.

Behaviour:
- Reset, asynchronous, any cycle:
  - data_gnt_o=0, data_rvalid_o=0, data_rdata_o=0, data_err_o=0, outstanding_o=0.
  - Stall counter, queue and timestamp counter cleared; in-flight transactions are dropped.
  - Memory contents are not reset.
- Grant:
  - data_gnt_o = data_req_i && stall_cnt==0 && count<MAX_OUTSTANDING. Combinational from req, same cycle.
  - count is the registered queue occupancy. A pop in the same cycle does NOT free a slot for that cycle's grant.
- Handshake = req && gnt. On a handshake:
  - stall_cnt loads gnt_stall_i.
  - Otherwise stall_cnt decrements while nonzero, independent of req.
  - gnt_stall_i=0 allows back-to-back grants every cycle.
- Address decode:
  - word index = data_addr_i[ADDR_WIDTH+1:2]; addr[1:0] is ignored.
  - If data_addr_i[31:ADDR_WIDTH+2] != 0, the access is an error: no memory write, response err=1, rdata=32'hBADC0DE0.
- Memory access happens in the handshake cycle:
  - Write: bytes selected by data_be_i are updated at the clock edge.
  - Read: the word is sampled in that cycle, so a later read sees an earlier write in order.
  - Write responses carry rdata=0, err=0 (unless address error).
- Queue entry = {rdata[31:0], err, ts[7:0]}, where ts is a free-running 8-bit cycle counter.
  - Push on handshake.
  - Head pops when (now_ts - head.ts) mod 256 >= RESP_LAT. Wrap-around is handled by the modular subtraction.
- Response outputs:
  - data_rvalid_o, data_rdata_o and data_err_o are registered; they present the popped entry for exactly one cycle.
  - At most one response per cycle. Strict in-order. No back-pressure on rvalid.
  - Between responses rdata holds its last value; err returns to 0.
- Latency:
  - Read granted at cycle t gives rvalid at t+RESP_LAT+1: one cycle for the push register and one for the output register, so RESP_LAT=1 gives rvalid at t+2.
  - A full queue throttles grants.
- outstanding_o = registered count. Push and pop in the same cycle leave count unchanged.
- data_req_i dropping without a grant is tolerated; no state changes.

Optional Feature:
- Macro OBI_RESP_RANDOM_STALL_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1 on reset) advances on every handshake.
  - stall_cnt loads lfsr[3:0] & gnt_stall_i, so gnt_stall_i acts as a mask.
- Undefined: stall_cnt loads gnt_stall_i directly and no LFSR logic exists.

Decomposition:
- Package obi_mem_pkg holds:
  - the resp_entry_t struct {rdata, err, ts};
  - constant ERR_RDATA=32'hBADC0DE0;
  - TS_WIDTH=8;
  - LFSR_SEED.
- One sub-module, obi_resp_fifo: a parameterised in-order queue of resp_entry_t with push, pop, head view and count.
- Grant/stall logic, memory and timestamp stay in the top.

Test Plan:
- Single read, gnt_stall_i=0, RESP_LAT=2, mem[5]=32'h12345678: req addr 0x14 → gnt same cycle, rvalid 3 cycles later, rdata=32'h12345678, err=0.
- Byte write be=4'b0010, wdata=32'hAABBCCDD to addr 0x20 holding 0; then read 0x20 → rdata=32'h0000CC00.
- Ten back-to-back reads, gnt_stall_i=0, hold core never stalled → ten consecutive grants, responses in order one per cycle, outstanding_o never exceeds 4.
- gnt_stall_i=3, continuous req → grants spaced 4 cycles apart.
- MAX_OUTSTANDING=2, RESP_LAT=10 → third request not granted until the first rvalid has registered; outstanding_o caps at 2.
- Address 0x0001_0000 read → err=1, rdata=32'hBADC0DE0, memory unchanged.
- Reset asserted with 3 in flight → rvalid stays 0 afterwards and outstanding_o=0.
